// File: rtl/stage_id_queue.sv
// stage_id_queue: DEPTH-entry instruction buffer between IF and dispatch,
// followed by one registered RV32I decode stage with register-file read,
// flush, back-pressure, occupancy reporting and illegal-opcode flagging.

`ifndef STAGE_ID_QUEUE_DEFS
`define STAGE_ID_QUEUE_DEFS
`define OpBus        4:0
`define CatagoryBus  2:0
`define OpAdd    5'd0
`define OpSub    5'd1
`define OpSll    5'd2
`define OpSlt    5'd3
`define OpSltu   5'd4
`define OpXor    5'd5
`define OpSrl    5'd6
`define OpSra    5'd7
`define OpOr     5'd8
`define OpAnd    5'd9
`define OpBeq    5'd10
`define OpBne    5'd11
`define OpBlt    5'd12
`define OpBge    5'd13
`define OpBltu   5'd14
`define OpBgeu   5'd15
`define OpLb     5'd16
`define OpLh     5'd17
`define OpLw     5'd18
`define OpLbu    5'd19
`define OpLhu    5'd20
`define OpSb     5'd21
`define OpSh     5'd22
`define OpSw     5'd23
`define OpJal    5'd24
`define OpJalr   5'd25
`define CatagoryArith    3'd0
`define CatagoryShift    3'd1
`define CatagoryLogic    3'd2
`define CatagoryCompare  3'd3
`define CatagoryBranch   3'd4
`define CatagoryJump     3'd5
`define CatagoryLoad     3'd6
`define CatagoryStore    3'd7
`endif

module stage_id_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int XLEN  = 32
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                flush_in,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_pc,
  input  logic [31:0]         in_inst,
  input  logic [XLEN-1:0]     in_npc,
  input  logic                in_predict,
  output logic [4:0]          read_addr1,
  input  logic [XLEN-1:0]     read_data1,
  output logic [4:0]          read_addr2,
  input  logic [XLEN-1:0]     read_data2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [XLEN-1:0]     out_npc,
  output logic                out_predict,
  output logic [`OpBus]       out_op,
  output logic [`CatagoryBus] out_catagory,
  output logic [4:0]          out_rs1_addr,
  output logic [4:0]          out_rs2_addr,
  output logic [4:0]          out_rd_addr,
  output logic                out_rs1_request,
  output logic                out_rs2_request,
  output logic [XLEN-1:0]     out_rs1_data,
  output logic [XLEN-1:0]     out_rs2_data,
  output logic [XLEN-1:0]     out_imm1,
  output logic [XLEN-1:0]     out_imm2,
  output logic                out_imm_rs1_sel,
  output logic                out_imm_rs2_sel,
  output logic                out_rd_write,
  output logic                out_rd_load,
  output logic                out_branch,
  output logic                out_jump,
  output logic                out_illegal,
  output logic [PTR_W:0]      occupancy
);

  localparam logic [PTR_W:0] FULL_CNT   = (PTR_W+1)'(DEPTH);
  localparam logic [6:0]     OPC_LUI    = 7'b0110111;
  localparam logic [6:0]     OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0]     OPC_JAL    = 7'b1101111;
  localparam logic [6:0]     OPC_JALR   = 7'b1100111;
  localparam logic [6:0]     OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]     OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]     OPC_STORE  = 7'b0100011;
  localparam logic [6:0]     OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0]     OPC_OP     = 7'b0110011;
  localparam logic [6:0]     OPC_FENCE  = 7'b0001111;
  localparam logic [6:0]     OPC_SYSTEM = 7'b1110011;

  // Widen a 32-bit sign-extended immediate to XLEN.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    sext32 = XLEN'($signed(v));
  endfunction

  // Buffer storage and pointers
  logic [XLEN-1:0] pc_mem_r   [DEPTH];
  logic [31:0]     inst_mem_r [DEPTH];
  logic [XLEN-1:0] npc_mem_r  [DEPTH];
  logic            pred_mem_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [PTR_W:0]   count_r;

  logic push_s;
  logic pop_s;

  // Head entry and its fields
  logic [XLEN-1:0] head_pc_s;
  logic [31:0]     head_inst_s;
  logic [XLEN-1:0] head_npc_s;
  logic            head_pred_s;
  logic [6:0]      opcode_s;
  logic [2:0]      funct3_s;
  logic [6:0]      funct7_s;
  logic [4:0]      rs1_s;
  logic [4:0]      rs2_s;
  logic [4:0]      rd_s;
  logic [XLEN-1:0] imm_i_s;
  logic [XLEN-1:0] imm_s_s;
  logic [XLEN-1:0] imm_b_s;
  logic [XLEN-1:0] imm_u_s;
  logic [XLEN-1:0] shamt_s;

  // Decoded bundle
  logic [`OpBus]       dec_op_s;
  logic [`CatagoryBus] dec_cat_s;
  logic                dec_rs1_req_s;
  logic                dec_rs2_req_s;
  logic                dec_rd_write_s;
  logic                dec_rd_load_s;
  logic                dec_branch_s;
  logic                dec_jump_s;
  logic                dec_illegal_s;
  logic                dec_sel1_s;
  logic                dec_sel2_s;
  logic [XLEN-1:0]     dec_imm1_s;
  logic [XLEN-1:0]     dec_imm2_s;
  logic [4:0]          dec_rs1_addr_s;
  logic [4:0]          dec_rs2_addr_s;
  logic [4:0]          dec_rd_addr_s;
  logic [XLEN-1:0]     dec_rs1_data_s;
  logic [XLEN-1:0]     dec_rs2_data_s;

  // No full-bypass: in_ready depends only on the registered count.
  assign in_ready  = (count_r != FULL_CNT);
  assign occupancy = count_r;
  assign push_s    = in_valid & in_ready & rdy_in;
  assign pop_s     = (count_r != {(PTR_W+1){1'b0}}) & (~out_valid | out_ready) & rdy_in;

  assign head_pc_s   = pc_mem_r[head_r];
  assign head_inst_s = inst_mem_r[head_r];
  assign head_npc_s  = npc_mem_r[head_r];
  assign head_pred_s = pred_mem_r[head_r];

  assign opcode_s = head_inst_s[6:0];
  assign rd_s     = head_inst_s[11:7];
  assign funct3_s = head_inst_s[14:12];
  assign rs1_s    = head_inst_s[19:15];
  assign rs2_s    = head_inst_s[24:20];
  assign funct7_s = head_inst_s[31:25];

  assign read_addr1 = rs1_s;
  assign read_addr2 = rs2_s;

  assign imm_i_s = sext32({{20{head_inst_s[31]}}, head_inst_s[31:20]});
  assign imm_s_s = sext32({{20{head_inst_s[31]}}, head_inst_s[31:25], head_inst_s[11:7]});
  assign imm_b_s = sext32({{19{head_inst_s[31]}}, head_inst_s[31], head_inst_s[7],
                           head_inst_s[30:25], head_inst_s[11:8], 1'b0});
  assign imm_u_s = sext32({head_inst_s[31:12], 12'd0});
  assign shamt_s = XLEN'(head_inst_s[24:20]);

  // Decode the head entry into the next output bundle.
  always_comb begin
    dec_op_s       = `OpAdd;
    dec_cat_s      = `CatagoryArith;
    dec_rs1_req_s  = 1'b0;
    dec_rs2_req_s  = 1'b0;
    dec_rd_write_s = 1'b0;
    dec_rd_load_s  = 1'b0;
    dec_branch_s   = 1'b0;
    dec_jump_s     = 1'b0;
    dec_illegal_s  = 1'b0;
    dec_sel1_s     = 1'b0;
    dec_sel2_s     = 1'b0;
    dec_imm1_s     = {XLEN{1'b0}};
    dec_imm2_s     = {XLEN{1'b0}};
    case (opcode_s)
      OPC_LUI: begin
        dec_rd_write_s = 1'b1;
        dec_imm2_s     = imm_u_s;
      end
      OPC_AUIPC: begin
        dec_rd_write_s = 1'b1;
        dec_imm1_s     = head_pc_s;
        dec_imm2_s     = imm_u_s;
      end
      OPC_JAL: begin
        dec_op_s       = `OpJal;
        dec_cat_s      = `CatagoryJump;
        dec_jump_s     = 1'b1;
        dec_rd_write_s = 1'b1;
        dec_imm1_s     = head_pc_s;
        dec_imm2_s     = XLEN'(32'd4);
      end
      OPC_JALR: begin
        dec_op_s       = `OpJalr;
        dec_cat_s      = `CatagoryJump;
        dec_jump_s     = 1'b1;
        dec_rd_write_s = 1'b1;
        dec_rs1_req_s  = 1'b1;
        dec_imm1_s     = head_pc_s;
        dec_imm2_s     = XLEN'(32'd4);
      end
      OPC_BRANCH: begin
        dec_cat_s     = `CatagoryBranch;
        dec_branch_s  = 1'b1;
        dec_rs1_req_s = 1'b1;
        dec_rs2_req_s = 1'b1;
        dec_sel1_s    = 1'b1;
        dec_sel2_s    = 1'b1;
        dec_imm1_s    = head_pc_s;
        dec_imm2_s    = imm_b_s;
        case (funct3_s)
          3'b001:  dec_op_s = `OpBne;
          3'b100:  dec_op_s = `OpBlt;
          3'b101:  dec_op_s = `OpBge;
          3'b110:  dec_op_s = `OpBltu;
          3'b111:  dec_op_s = `OpBgeu;
          default: dec_op_s = `OpBeq;
        endcase
      end
      OPC_LOAD: begin
        dec_cat_s      = `CatagoryLoad;
        dec_rs1_req_s  = 1'b1;
        dec_sel1_s     = 1'b1;
        dec_rd_write_s = 1'b1;
        dec_rd_load_s  = 1'b1;
        dec_imm2_s     = imm_i_s;
        case (funct3_s)
          3'b000:  dec_op_s = `OpLb;
          3'b001:  dec_op_s = `OpLh;
          3'b100:  dec_op_s = `OpLbu;
          3'b101:  dec_op_s = `OpLhu;
          default: dec_op_s = `OpLw;
        endcase
      end
      OPC_STORE: begin
        dec_cat_s     = `CatagoryStore;
        dec_rs1_req_s = 1'b1;
        dec_rs2_req_s = 1'b1;
        dec_sel1_s    = 1'b1;
        dec_sel2_s    = 1'b1;
        dec_imm2_s    = imm_s_s;
        case (funct3_s)
          3'b000:  dec_op_s = `OpSb;
          3'b001:  dec_op_s = `OpSh;
          default: dec_op_s = `OpSw;
        endcase
      end
      OPC_OPIMM: begin
        dec_rs1_req_s  = 1'b1;
        dec_sel1_s     = 1'b1;
        dec_rd_write_s = 1'b1;
        dec_imm2_s     = imm_i_s;
        case (funct3_s)
          3'b001: begin
            dec_op_s   = `OpSll;
            dec_cat_s  = `CatagoryShift;
            dec_imm2_s = shamt_s;
          end
          3'b101: begin
            dec_op_s   = (funct7_s != 7'd0) ? `OpSra : `OpSrl;
            dec_cat_s  = `CatagoryShift;
            dec_imm2_s = shamt_s;
          end
          3'b010: begin
            dec_op_s  = `OpSlt;
            dec_cat_s = `CatagoryCompare;
          end
          3'b011: begin
            dec_op_s  = `OpSltu;
            dec_cat_s = `CatagoryCompare;
          end
          3'b100: begin
            dec_op_s  = `OpXor;
            dec_cat_s = `CatagoryLogic;
          end
          3'b110: begin
            dec_op_s  = `OpOr;
            dec_cat_s = `CatagoryLogic;
          end
          3'b111: begin
            dec_op_s  = `OpAnd;
            dec_cat_s = `CatagoryLogic;
          end
          default: dec_op_s = `OpAdd;
        endcase
      end
      OPC_OP: begin
        dec_rs1_req_s  = 1'b1;
        dec_rs2_req_s  = 1'b1;
        dec_sel1_s     = 1'b1;
        dec_sel2_s     = 1'b1;
        dec_rd_write_s = 1'b1;
        case (funct3_s)
          3'b001: begin
            dec_op_s  = `OpSll;
            dec_cat_s = `CatagoryShift;
          end
          3'b101: begin
            dec_op_s  = (funct7_s != 7'd0) ? `OpSra : `OpSrl;
            dec_cat_s = `CatagoryShift;
          end
          3'b010: begin
            dec_op_s  = `OpSlt;
            dec_cat_s = `CatagoryCompare;
          end
          3'b011: begin
            dec_op_s  = `OpSltu;
            dec_cat_s = `CatagoryCompare;
          end
          3'b100: begin
            dec_op_s  = `OpXor;
            dec_cat_s = `CatagoryLogic;
          end
          3'b110: begin
            dec_op_s  = `OpOr;
            dec_cat_s = `CatagoryLogic;
          end
          3'b111: begin
            dec_op_s  = `OpAnd;
            dec_cat_s = `CatagoryLogic;
          end
          default: dec_op_s = head_inst_s[30] ? `OpSub : `OpAdd;
        endcase
      end
      // FENCE and SYSTEM are base-set opcodes with no architectural effect here.
      OPC_FENCE:  dec_op_s = `OpAdd;
      OPC_SYSTEM: dec_op_s = `OpAdd;
      default:    dec_illegal_s = 1'b1;
    endcase
  end

  // Register indices and operand data; unused or x0 sources read as zero.
  always_comb begin
    dec_rs1_addr_s = dec_rs1_req_s ? rs1_s : 5'd0;
    dec_rs2_addr_s = dec_rs2_req_s ? rs2_s : 5'd0;
    dec_rd_addr_s  = dec_rd_write_s ? rd_s : 5'd0;
    dec_rs1_data_s = (dec_rs1_req_s && (rs1_s != 5'd0)) ? read_data1 : {XLEN{1'b0}};
    dec_rs2_data_s = (dec_rs2_req_s && (rs2_s != 5'd0)) ? read_data2 : {XLEN{1'b0}};
  end

  // Buffer write port: store the IF entry on an accepted, unflushed push.
  always_ff @(posedge clk_in) begin
    if (!rst_in && push_s && !flush_in) begin
      pc_mem_r[tail_r]   <= in_pc;
      inst_mem_r[tail_r] <= in_inst;
      npc_mem_r[tail_r]  <= in_npc;
      pred_mem_r[tail_r] <= in_predict;
    end
  end

  // Head/tail pointers and occupancy count; flush empties the buffer.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {(PTR_W+1){1'b0}};
    end else if (rdy_in) begin
      if (flush_in) begin
        head_r  <= {PTR_W{1'b0}};
        tail_r  <= {PTR_W{1'b0}};
        count_r <= {(PTR_W+1){1'b0}};
      end else begin
        if (push_s) tail_r <= tail_r + PTR_W'(1);
        if (pop_s)  head_r <= head_r + PTR_W'(1);
        case ({push_s, pop_s})
          2'b10:   count_r <= count_r + (PTR_W+1)'(1);
          2'b01:   count_r <= count_r - (PTR_W+1)'(1);
          default: count_r <= count_r;
        endcase
      end
    end
  end

  // Output register: load on pop, drop valid once dispatch takes the bundle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      out_valid       <= 1'b0;
      out_pc          <= {XLEN{1'b0}};
      out_npc         <= {XLEN{1'b0}};
      out_predict     <= 1'b0;
      out_op          <= `OpAdd;
      out_catagory    <= `CatagoryArith;
      out_rs1_addr    <= 5'd0;
      out_rs2_addr    <= 5'd0;
      out_rd_addr     <= 5'd0;
      out_rs1_request <= 1'b0;
      out_rs2_request <= 1'b0;
      out_rs1_data    <= {XLEN{1'b0}};
      out_rs2_data    <= {XLEN{1'b0}};
      out_imm1        <= {XLEN{1'b0}};
      out_imm2        <= {XLEN{1'b0}};
      out_imm_rs1_sel <= 1'b0;
      out_imm_rs2_sel <= 1'b0;
      out_rd_write    <= 1'b0;
      out_rd_load     <= 1'b0;
      out_branch      <= 1'b0;
      out_jump        <= 1'b0;
      out_illegal     <= 1'b0;
    end else if (rdy_in) begin
      if (flush_in) begin
        out_valid <= 1'b0;
      end else if (pop_s) begin
        out_valid       <= 1'b1;
        out_pc          <= head_pc_s;
        out_npc         <= head_npc_s;
        out_predict     <= head_pred_s;
        out_op          <= dec_op_s;
        out_catagory    <= dec_cat_s;
        out_rs1_addr    <= dec_rs1_addr_s;
        out_rs2_addr    <= dec_rs2_addr_s;
        out_rd_addr     <= dec_rd_addr_s;
        out_rs1_request <= dec_rs1_req_s;
        out_rs2_request <= dec_rs2_req_s;
        out_rs1_data    <= dec_rs1_data_s;
        out_rs2_data    <= dec_rs2_data_s;
        out_imm1        <= dec_imm1_s;
        out_imm2        <= dec_imm2_s;
        out_imm_rs1_sel <= dec_sel1_s;
        out_imm_rs2_sel <= dec_sel2_s;
        out_rd_write    <= dec_rd_write_s;
        out_rd_load     <= dec_rd_load_s;
        out_branch      <= dec_branch_s;
        out_jump        <= dec_jump_s;
        out_illegal     <= dec_illegal_s;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stage_id_queue.sv
// Directed self-checking bench for stage_id_queue (DEPTH=4, XLEN=32).
module tb_stage_id_queue;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_SRA  = 5'd7;
  localparam logic [2:0] CAT_ARITH = 3'd0;
  localparam logic [2:0] CAT_JUMP  = 3'd5;

  localparam logic [31:0] I_ADDI = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] I_SUB  = 32'h402081B3; // sub x3,x1,x2
  localparam logic [31:0] I_JAL  = 32'h008000EF; // jal x1,+8
  localparam logic [31:0] I_SRAI = 32'h4032D293; // srai x5,x5,3
  localparam logic [31:0] I_ILL  = 32'h0000007F;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush_in, in_valid, in_predict, out_ready;
  logic        in_ready, out_valid, out_predict;
  logic [31:0] in_pc, in_inst, in_npc, read_data1, read_data2;
  logic [4:0]  read_addr1, read_addr2;
  logic [31:0] out_pc, out_npc, out_rs1_data, out_rs2_data, out_imm1, out_imm2;
  logic [4:0]  out_op, out_rs1_addr, out_rs2_addr, out_rd_addr;
  logic [2:0]  out_catagory, occupancy;
  logic        out_rs1_request, out_rs2_request, out_imm_rs1_sel, out_imm_rs2_sel;
  logic        out_rd_write, out_rd_load, out_branch, out_jump, out_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  // Register file model: x1=7, x2=2, everything else 0x1000+index (x0 too).
  function automatic logic [31:0] rf(input logic [4:0] a);
    case (a)
      5'd1:    return 32'd7;
      5'd2:    return 32'd2;
      default: return 32'h1000 + {27'd0, a};
    endcase
  endfunction

  assign read_data1 = rf(read_addr1);
  assign read_data2 = rf(read_addr2);

  stage_id_queue #(.DEPTH(4), .PTR_W(2), .XLEN(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .in_npc(in_npc), .in_predict(in_predict),
    .read_addr1(read_addr1), .read_data1(read_data1),
    .read_addr2(read_addr2), .read_data2(read_data2),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_npc(out_npc),
    .out_predict(out_predict), .out_op(out_op), .out_catagory(out_catagory),
    .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr), .out_rd_addr(out_rd_addr),
    .out_rs1_request(out_rs1_request), .out_rs2_request(out_rs2_request),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_imm1(out_imm1), .out_imm2(out_imm2),
    .out_imm_rs1_sel(out_imm_rs1_sel), .out_imm_rs2_sel(out_imm_rs2_sel),
    .out_rd_write(out_rd_write), .out_rd_load(out_rd_load),
    .out_branch(out_branch), .out_jump(out_jump), .out_illegal(out_illegal),
    .occupancy(occupancy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] inst,
                       input logic [31:0] npc, input logic pred);
    in_valid   = 1'b1;
    in_pc      = pc;
    in_inst    = inst;
    in_npc     = npc;
    in_predict = pred;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; in_valid = 1'b0;
    in_pc = 32'd0; in_inst = 32'd0; in_npc = 32'd0; in_predict = 1'b0;
    out_ready = 1'b0;
    step(); step();
    rst_in = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_occ", occupancy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_pc", out_pc, 0);
    check("rst_rd_write", out_rd_write, 0);

    // Back-to-back stream of three addi entries
    out_ready = 1'b1;
    drive(32'h0, I_ADDI, 32'h4, 1'b0); step();
    check("s1_occ", occupancy, 1);
    check("s1_valid", out_valid, 0);
    drive(32'h4, I_ADDI, 32'h8, 1'b0); step();
    check("s2_valid", out_valid, 1);
    check("s2_pc", out_pc, 32'h0);
    check("s2_rd", out_rd_addr, 1);
    check("s2_imm2", out_imm2, 5);
    check("s2_sel2", out_imm_rs2_sel, 0);
    check("s2_sel1", out_imm_rs1_sel, 1);
    check("s2_rs1_data", out_rs1_data, 0);
    check("s2_rd_write", out_rd_write, 1);
    check("s2_op", out_op, OP_ADD);
    drive(32'h8, I_ADDI, 32'hC, 1'b0); step();
    check("s3_pc", out_pc, 32'h4);
    check("s3_valid", out_valid, 1);
    in_valid = 1'b0; step();
    check("s4_pc", out_pc, 32'h8);
    check("s4_occ", occupancy, 0);
    step();
    check("s5_valid", out_valid, 0);

    // Fill with back-pressure, refuse push when full, then drain in order
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(32'h40 + 32'(4 * k), I_ADDI, 32'h0, 1'b0); step();
    end
    check("full_occ", occupancy, 4);
    check("full_in_ready", in_ready, 0);
    check("full_out_pc", out_pc, 32'h40);
    check("full_valid", out_valid, 1);
    drive(32'h54, I_ADDI, 32'h0, 1'b0); step();
    check("refused_occ", occupancy, 4);
    check("refused_out_pc", out_pc, 32'h40);
    out_ready = 1'b1; step();
    check("popfull_occ", occupancy, 3);
    check("popfull_out_pc", out_pc, 32'h44);
    check("popfull_in_ready", in_ready, 1);
    for (int j = 0; j < 8; j++) begin
      drive(32'h54 + 32'(4 * j), I_ADDI, 32'h0, 1'b0); step();
      check("wrap_out_pc", out_pc, 32'h48 + 32'(4 * j));
      check("wrap_occ", occupancy, 3);
    end
    in_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step();
      check("drain_out_pc", out_pc, 32'h68 + 32'(4 * j));
      check("drain_occ", occupancy, 64'(2 - j));
    end
    step();
    check("drain_done", out_valid, 0);

    // Flush with occupancy 3, a valid bundle and a concurrent push
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(32'h200 + 32'(4 * k), I_ADDI, 32'h0, 1'b0); step();
    end
    check("pre_flush_occ", occupancy, 3);
    check("pre_flush_valid", out_valid, 1);
    drive(32'h300, I_ADDI, 32'h0, 1'b0); flush_in = 1'b1; step();
    flush_in = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("flush_occ", occupancy, 0);
    check("flush_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    for (int j = 0; j < 3; j++) begin
      step();
      check("post_flush_valid", out_valid, 0);
      check("post_flush_occ", occupancy, 0);
    end

    // Decode sequence, stalled then released
    out_ready = 1'b0;
    drive(32'hF0, I_SUB, 32'hF4, 1'b0); step();
    drive(32'h100, I_JAL, 32'h108, 1'b1); step();
    drive(32'h104, I_SRAI, 32'h108, 1'b0); step();
    drive(32'h108, I_ILL, 32'h10C, 1'b0); step();
    in_valid = 1'b0;
    check("sub_op", out_op, OP_SUB);
    check("sub_rs1_data", out_rs1_data, 7);
    check("sub_rs2_data", out_rs2_data, 2);
    check("sub_rd", out_rd_addr, 3);
    check("sub_rs1_addr", out_rs1_addr, 1);
    check("sub_rs2_addr", out_rs2_addr, 2);
    check("sub_sel2", out_imm_rs2_sel, 1);
    check("sub_rd_load", out_rd_load, 0);
    out_ready = 1'b1; step();
    check("jal_pc", out_pc, 32'h100);
    check("jal_imm1", out_imm1, 32'h100);
    check("jal_imm2", out_imm2, 4);
    check("jal_jump", out_jump, 1);
    check("jal_branch", out_branch, 0);
    check("jal_rd", out_rd_addr, 1);
    check("jal_rs1_req", out_rs1_request, 0);
    check("jal_predict", out_predict, 1);
    check("jal_npc", out_npc, 32'h108);
    check("jal_cat", out_catagory, CAT_JUMP);
    step();
    check("srai_imm2", out_imm2, 3);
    check("srai_op", out_op, OP_SRA);
    check("srai_rs1_data", out_rs1_data, 32'h1005);
    check("srai_rs2_req", out_rs2_request, 0);
    check("srai_rs2_data", out_rs2_data, 0);
    check("srai_rd", out_rd_addr, 5);
    step();
    check("ill_flag", out_illegal, 1);
    check("ill_valid", out_valid, 1);
    check("ill_rd_write", out_rd_write, 0);
    check("ill_op", out_op, OP_ADD);
    check("ill_cat", out_catagory, CAT_ARITH);
    check("ill_rs1_req", out_rs1_request, 0);
    check("ill_jump", out_jump, 0);
    step();
    check("dec_done_valid", out_valid, 0);
    check("dec_done_occ", occupancy, 0);

    // Freeze via rdy_in mid-stream (flush ignored while frozen)
    drive(32'h400, I_ADDI, 32'h0, 1'b0); step();
    drive(32'h404, I_ADDI, 32'h0, 1'b0); step();
    drive(32'h408, I_ADDI, 32'h0, 1'b0); step();
    check("prefreeze_pc", out_pc, 32'h404);
    check("prefreeze_occ", occupancy, 1);
    drive(32'h40C, I_ADDI, 32'h0, 1'b0);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      flush_in = (i == 1);
      step();
      check("freeze_pc", out_pc, 32'h404);
      check("freeze_valid", out_valid, 1);
      check("freeze_occ", occupancy, 1);
    end
    flush_in = 1'b0;
    rdy_in = 1'b1; step();
    check("resume_pc", out_pc, 32'h408);
    check("resume_occ", occupancy, 1);
    in_valid = 1'b0; step();
    check("resume2_pc", out_pc, 32'h40C);
    check("resume2_occ", occupancy, 0);
    step();
    check("resume_done", out_valid, 0);

    // Reset dominates rdy_in=0
    out_ready = 1'b0;
    drive(32'h500, I_ADDI, 32'h0, 1'b0); step();
    in_valid = 1'b0;
    check("prerst_occ", occupancy, 1);
    rdy_in = 1'b0; rst_in = 1'b1; step();
    check("rst2_occ", occupancy, 0);
    check("rst2_valid", out_valid, 0);
    check("rst2_out_pc", out_pc, 0);
    rst_in = 1'b0; rdy_in = 1'b1; step();
    check("rst2_in_ready", in_ready, 1);
    check("rst2_valid_after", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
